// File: rtl/tanh_cordic_sched_pkg.sv
// Shared definitions for the tanh CORDIC scheduler: FP32 field positions,
// FSM state encoding and the launch/wait counter width helper.
package tanh_cordic_sched_pkg;

  localparam int FP32_W  = 32;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Counter wide enough to count up to the larger of the EN pulse length
  // and the core latency.
  function automatic int cnt_width(input int en_cycles, input int core_latency);
    return $clog2(((en_cycles > core_latency) ? en_cycles : core_latency) + 1);
  endfunction

endpackage

// File: rtl/tanh_cordic_sched_if.sv
// Bundle of requester, response and core-side signals of the scheduler.
//
// Handshake rules: a transfer happens on a rising clk edge where valid and
// ready are both high. A source that raises valid keeps valid and its data
// stable until that edge (requesters may withdraw valid before a grant; the
// request is then simply not taken). ready may depend combinationally on
// valid. On the response side rsp_data/rsp_id hold until rsp_ready is seen.
interface tanh_cordic_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DWIDTH = 32
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DWIDTH-1:0] req_data;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DWIDTH-1:0]       rsp_data;
  logic [IDW-1:0]          rsp_id;
  logic                    core_en;
  logic [DWIDTH-1:0]       core_z;
  logic [DWIDTH-1:0]       core_out;
  logic                    busy;

  // Scheduler side
  modport slave (
    input  req_valid, req_data, rsp_ready, core_out,
    output req_ready, rsp_valid, rsp_data, rsp_id, core_en, core_z, busy
  );

  // Requesters / consumer / core side
  modport master (
    output req_valid, req_data, rsp_ready, core_out,
    input  req_ready, rsp_valid, rsp_data, rsp_id, core_en, core_z, busy
  );

endinterface

// File: rtl/tanh_cordic_sched_rr_arbiter.sv
// Combinational round-robin arbiter: given a request vector and the index of
// the last grant, grants the first requester after it (wrapping). Reusable by
// other serial schedulers.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_last,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDW-1:0]   o_idx,
  output logic             o_any
);

  // Index k steps after the last grant, wrapped into 0..N_REQ-1.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] last, input int k);
    int s;
    s = int'(last) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  // Scan from last+1 around to last; the first active request wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!o_any && i_req[wrap_idx(i_last, k)]) begin
        o_any                      = 1'b1;
        o_grant[wrap_idx(i_last, k)] = 1'b1;
        o_idx                      = wrap_idx(i_last, k);
      end
    end
  end

endmodule

// File: rtl/tanh_cordic_sched.sv
// Round-robin scheduler sharing one iterative tanh CORDIC core among N_REQ
// requesters. One operation is in flight at a time:
//   IDLE -> LAUNCH (core_en for EN_CYCLES) -> WAIT (CORE_LATENCY) -> RESP.
// Optional feature macro: TANH_SCHED_ZERO_BYPASS_EN -- operands with a zero
// exponent field (+-0, denormals) skip the core and are returned unchanged.
module tanh_cordic_sched
  import tanh_cordic_sched_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DWIDTH       = 32,
  parameter int EN_CYCLES    = 2,
  parameter int CORE_LATENCY = 100
) (
  input  logic                clk,
  input  logic                rst,
  tanh_cordic_sched_if.slave  bus,
  output state_t              o_dbg_state
);

  localparam int IDW   = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(EN_CYCLES, CORE_LATENCY);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDW-1:0]      r_rr_ptr;
  logic [IDW-1:0]      r_id;
  logic [DWIDTH-1:0]   r_core_z;
  logic                r_core_en;
  logic                r_rsp_valid;
  logic [DWIDTH-1:0]   r_rsp_data;

  logic [N_REQ-1:0]    w_grant;
  logic [IDW-1:0]      w_gidx;
  logic                w_any;
  logic [DWIDTH-1:0]   w_gdata;
  logic                w_zero_exp;

  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .i_req   (bus.req_valid),
    .i_last  (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  // Operand mux for the requester being granted this cycle.
  always_comb begin
    w_gdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gidx == IDW'(k)) w_gdata = bus.req_data[k*DWIDTH +: DWIDTH];
    end
  end

  assign w_zero_exp = (w_gdata[EXP_MSB:EXP_LSB] == '0);

  // Grant is only offered while idle; at most one bit is ever high.
  assign bus.req_ready = (r_state == ST_IDLE) ? w_grant : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_id;
  assign bus.core_en   = r_core_en;
  assign bus.core_z    = r_core_z;
  assign bus.busy      = (r_state != ST_IDLE);
  assign o_dbg_state   = r_state;

  // Scheduler FSM: grant, pulse the core, wait out its latency, hand back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rr_ptr    <= IDW'(N_REQ - 1);
      r_id        <= '0;
      r_core_z    <= '0;
      r_core_en   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_core_z <= w_gdata;
            r_id     <= w_gidx;
            r_rr_ptr <= w_gidx;
            r_cnt    <= '0;
`ifdef TANH_SCHED_ZERO_BYPASS_EN
            if (w_zero_exp) begin
              // tanh(x) == x to FP32 precision here; the core is not used.
              r_rsp_data  <= w_gdata;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_core_en <= 1'b1;
              r_state   <= ST_LAUNCH;
            end
`else
            r_core_en <= 1'b1;
            r_state   <= ST_LAUNCH;
`endif
          end
        end
        ST_LAUNCH: begin
          if (r_cnt == CNT_W'(EN_CYCLES - 1)) begin
            r_core_en <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_cnt == CNT_W'(CORE_LATENCY - 1)) begin
            r_rsp_data  <= bus.core_out;
            r_rsp_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The zero-exponent flag is only consumed by the bypass build.
  logic w_unused;
  assign w_unused = w_zero_exp;

endmodule

// File: tb/tb_tanh_cordic_sched.sv
// Self-checking bench for tanh_cordic_sched: requester driver, behavioural
// core model, grant/response scoreboard and directed scenarios.
module tb_tanh_cordic_sched;
  import tanh_cordic_sched_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int ENC  = 2;
  localparam int LAT  = 100;
  localparam int IDW  = $clog2(N);
  localparam int SB_W = 1 + 32 + IDW + DW;  // {bypass, exp_cycle, id, data}
  localparam logic [DW-1:0] GARBAGE = 32'hdeadbeef;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     core_en_total = 0;

  logic [SB_W-1:0] exp_q[$];
  int              grant_log[$];
  logic [DW-1:0]   op_q[N][$];
  logic [N-1:0]    acc_mask = '0;

  tanh_cordic_sched_if #(.N_REQ(N), .DWIDTH(DW)) bus ();

  tanh_cordic_sched #(
    .N_REQ(N), .DWIDTH(DW), .EN_CYCLES(ENC), .CORE_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stand-in for the real CORDIC: the known tanh(1.0) value and an arbitrary
  // bijection elsewhere, so pass-through mistakes are visible.
  function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] z);
    if (z == 32'h3f800000) return 32'h3f42f7d6;
    return {z[31], z[30:0] ^ 31'h02a5c3b1};
  endfunction

  function automatic logic is_bypass(input logic [DW-1:0] z);
`ifdef TANH_SCHED_ZERO_BYPASS_EN
    return (z[30:23] == 8'd0);
`else
    return (z[31] & ~z[31]);
`endif
  endfunction

  // ---------------- requester driver ----------------
  // Presents the head of each requester's operand queue; pops it after the
  // accepting edge so valid stays high while more operands are queued.
  initial begin
    logic [DW-1:0] tmp;
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc_mask[k] && op_q[k].size() != 0) tmp = op_q[k].pop_front();
        if (op_q[k].size() != 0) begin
          bus.req_valid[k]         = 1'b1;
          bus.req_data[k*DW +: DW] = op_q[k][0];
        end else begin
          bus.req_valid[k] = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor, scoreboard and core model ----------------
  initial begin
    int            model_ptr;
    int            gidx;
    int            exp_g;
    int            en_run;
    int            core_cnt;
    logic          last_en;
    logic          last_valid;
    logic          last_ready;
    logic [DW-1:0] prev_data;
    logic [IDW-1:0] prev_id;
    logic [DW-1:0] op;
    logic          bp;
    logic [SB_W-1:0] e;
    model_ptr = N - 1; en_run = 0; core_cnt = 0;
    last_en = 1'b0; last_valid = 1'b0; last_ready = 1'b0;
    prev_data = '0; prev_id = '0;
    bus.core_out = GARBAGE;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        model_ptr = N - 1; en_run = 0; core_cnt = 0;
        acc_mask = '0; last_en = 1'b0; last_valid = 1'b0; last_ready = 1'b0;
        bus.core_out = GARBAGE;
      end else begin
        acc_mask = bus.req_valid & bus.req_ready;
        // grants
        if (bus.req_ready != '0) begin
          check_eq("grant_onehot", 64'($countones(bus.req_ready)), 64'd1);
          check_eq("grant_has_valid", 64'(acc_mask), 64'(bus.req_ready));
          gidx = 0;
          for (int k = 0; k < N; k++) if (bus.req_ready[k]) gidx = k;
          exp_g = -1;
          for (int k = 1; k <= N; k++)
            if (exp_g < 0 && bus.req_valid[(model_ptr + k) % N]) exp_g = (model_ptr + k) % N;
          check_eq("grant_idx", 64'(gidx), 64'(exp_g));
          model_ptr = gidx;
          grant_log.push_back(gidx);
          op = DW'(bus.req_data >> (gidx * DW));
          bp = is_bypass(op);
          e  = {bp, 32'(cyc + (bp ? 1 : 1 + ENC + LAT)), IDW'(gidx), bp ? op : core_fn(op)};
          exp_q.push_back(e);
        end
        // responses
        if (bus.rsp_valid) begin
          if (exp_q.size() == 0) begin
            check_eq("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
          end else begin
            e = exp_q[0];
            if (!last_valid) check_eq("rsp_latency", 64'(cyc), 64'(e[SB_W-2 -: 32]));
            if (last_valid && !last_ready) begin
              check_eq("rsp_data_hold", 64'(bus.rsp_data), 64'(prev_data));
              check_eq("rsp_id_hold", 64'(bus.rsp_id), 64'(prev_id));
              check_eq("ready_in_stall", 64'(bus.req_ready), 64'd0);
            end
            if (bus.rsp_ready) begin
              check_eq("rsp_data", 64'(bus.rsp_data), 64'(e[DW-1:0]));
              check_eq("rsp_id", 64'(bus.rsp_id), 64'(e[DW+IDW-1 -: IDW]));
              e = exp_q.pop_front();
            end
          end
        end
        last_valid = bus.rsp_valid;
        last_ready = bus.rsp_ready;
        prev_data  = bus.rsp_data;
        prev_id    = bus.rsp_id;
        // core enable pulse and core model
        if (bus.core_en) begin
          if (!last_en && exp_q.size() != 0)
            check_eq("core_en_on_bypass", 64'(exp_q[0][SB_W-1]), 64'd0);
          en_run++;
          core_en_total++;
        end else if (last_en) begin
          check_eq("core_en_cycles", 64'(en_run), 64'(ENC));
          en_run       = 0;
          core_cnt     = LAT;
          bus.core_out = GARBAGE;
        end
        last_en = bus.core_en;
        if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0) bus.core_out = core_fn(bus.core_z);
        end
      end
    end
  end

  // ---------------- sequence helpers ----------------
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  function automatic logic all_idle();
    logic r;
    r = (exp_q.size() == 0) && !bus.busy && !bus.rsp_valid;
    for (int k = 0; k < N; k++) if (op_q[k].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_drain(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (all_idle()) break;
      step();
    end
    check_eq(tag, 64'(all_idle()), 64'd1);
  endtask

  function automatic logic [DW-1:0] rand_fp();
    logic [DW-1:0] v;
    v        = $urandom;
    v[30:23] = 8'($urandom_range(100, 140));
    return v;
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    int exp_order[8];
    int en_before;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // reset values
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    check_eq("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check_eq("rst_core_en", 64'(bus.core_en), 64'd0);
    check_eq("rst_core_z", 64'(bus.core_z), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (3) begin
      step();
      check_eq("idle_no_ready", 64'(bus.req_ready), 64'd0);
    end

    // single operation, tanh(1.0)
    bus.rsp_ready = 1'b1;
    op_q[0].push_back(32'h3f800000);
    wait_drain(400, "t2_drain");
    check_eq("t2_grant", 64'(grant_log[grant_log.size()-1]), 64'd0);

    // all requesters busy: round-robin from pointer 0
    base = grant_log.size();
    exp_order = '{1, 2, 3, 0, 1, 2, 3, 0};
    for (int k = 0; k < N; k++) begin
      op_q[k].push_back(rand_fp());
      op_q[k].push_back(rand_fp());
    end
    wait_drain(2000, "t3_drain");
    check_eq("t3_count", 64'(grant_log.size() - base), 64'd8);
    for (int i = 0; i < 8; i++)
      if (base + i < grant_log.size())
        check_eq("t3_order", 64'(grant_log[base+i]), 64'(exp_order[i]));

    // response stall
    bus.rsp_ready = 1'b0;
    op_q[0].push_back(rand_fp());
    for (int i = 0; i < 300 && !bus.rsp_valid; i++) step();
    check_eq("t4_rsp_seen", 64'(bus.rsp_valid), 64'd1);
    base = grant_log.size();
    op_q[2].push_back(rand_fp());
    repeat (50) step();
    check_eq("t4_no_grant", 64'(grant_log.size() - base), 64'd0);
    check_eq("t4_still_valid", 64'(bus.rsp_valid), 64'd1);
    bus.rsp_ready = 1'b1;
    wait_drain(400, "t4_drain");
    check_eq("t4_grant2", 64'(grant_log[grant_log.size()-1]), 64'd2);

    // reset during WAIT
    op_q[1].push_back(32'h3f000000);
    for (int i = 0; i < 20 && !bus.busy; i++) step();
    check_eq("t5_busy", 64'(bus.busy), 64'd1);
    repeat (40) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t5_core_en", 64'(bus.core_en), 64'd0);
    check_eq("t5_busy_low", 64'(bus.busy), 64'd0);
    check_eq("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("t5_state", 64'(dbg_state), 64'(ST_IDLE));
    base = grant_log.size();
    op_q[2].push_back(rand_fp());
    op_q[0].push_back(rand_fp());
    wait_drain(600, "t5_drain");
    check_eq("t5_count", 64'(grant_log.size() - base), 64'd2);
    if (grant_log.size() - base == 2) begin
      check_eq("t5_first", 64'(grant_log[base]), 64'd0);
      check_eq("t5_second", 64'(grant_log[base+1]), 64'd2);
    end

    // zero-exponent operands (bypass when enabled)
    en_before = core_en_total;
    op_q[3].push_back(32'h80000000);
    op_q[3].push_back(32'h00012345);
    wait_drain(600, "t6_drain");
`ifdef TANH_SCHED_ZERO_BYPASS_EN
    check_eq("t6_core_en", 64'(core_en_total - en_before), 64'd0);
`else
    check_eq("t6_core_en", 64'(core_en_total - en_before), 64'(2 * ENC));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
